fetch_unit: RTL and testbench

//   Parametrised instruction-fetch stage for the RISC-V core, replacing the bare PC register, PC+4 adder and PC mux.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: fetch PC, imem read issue, prefetch FIFO, redirect
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   imem_rd_en          read request to the synchronous instruction memory
//   imem_addr           word address of the request (fetch_pc[ADDR_WIDTH+1:2])
//   imem_data           read data, valid the cycle after imem_rd_en
//   redirect            taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc         byte address of the redirect target
//   instr_valid         FIFO head holds a valid instruction
//   instr_ready         decode accepts the head this cycle
//   instr, instr_pc     head instruction and its PC (0 when empty)
//   misaligned          one-cycle pulse after a redirect to a non word-aligned target

module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 10,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_rd_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]       imem_data,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [XLEN-1:0]       instr,
    output logic [XLEN-1:0]       instr_pc,
    output logic                  misaligned
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] fetch_pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;

    logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [CW-1:0]   occupancy;

    // Credit counts the outstanding read as already occupying a slot, so a
    // returning word always has room; a same-cycle pop is deliberately not
    // counted to keep the issue path independent of instr_ready.
    assign occupancy  = count + {{(CW-1){1'b0}}, inflight};
    assign imem_rd_en = (state_q == RUN) && !redirect && (occupancy < DEPTH_C);
    assign imem_addr  = fetch_pc[ADDR_WIDTH+1:2];

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_instr[head] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[head]    : '0;

    // Redirect squashes both the returning word and any hand-off to decode.
    assign push = inflight && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            misaligned  <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            if (redirect) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                // In BOOT nothing is queued or in flight, so only the PC moves.
                if (state_q == RUN) begin
                    head       <= '0;
                    tail       <= '0;
                    count      <= '0;
                    inflight   <= 1'b0;
                    misaligned <= |redirect_pc[1:0];
                end
            end else begin
                if (imem_rd_en) begin
                    fetch_pc    <= fetch_pc + XLEN'(4);
                    inflight_pc <= fetch_pc;
                end
                inflight <= imem_rd_en;
                if (push) begin
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[tail] <= imem_data;
            fifo_pc[tail]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rd_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misaligned;

    logic        reset2;
    logic        imem_rd_en2;
    logic [9:0]  imem_addr2;
    logic [31:0] imem_data2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        misaligned2;

    int n_checks = 0;
    int n_fail   = 0;
    int reads;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .misaligned  (misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk         (clk),
        .reset       (reset2),
        .imem_rd_en  (imem_rd_en2),
        .imem_addr   (imem_addr2),
        .imem_data   (imem_data2),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .instr_valid (instr_valid2),
        .instr_ready (instr_ready2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .misaligned  (misaligned2)
    );

    // Synchronous instruction memory: word = 0xA000_0000 | byte address.
    always @(posedge clk) begin
        if (imem_rd_en)  imem_data  <= 32'hA000_0000 | {20'h0, imem_addr, 2'b00};
        if (imem_rd_en2) imem_data2 <= 32'hA000_0000 | {20'h0, imem_addr2, 2'b00};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects reset high and instr_ready=1; releases reset and checks the boot sequence.
    task automatic release_and_check_boot(input string pfx);
        tick();
        reset = 1'b0;
        #1;
        check({pfx, "_boot_rd_en"}, 32'(imem_rd_en), 32'h0);
        tick();
        check({pfx, "_c1_rd_en"}, 32'(imem_rd_en), 32'h1);
        check({pfx, "_c1_valid"}, 32'(instr_valid), 32'h0);
        tick();
        check({pfx, "_c2_valid"}, 32'(instr_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check({pfx, "_seq_valid"}, 32'(instr_valid), 32'h1);
            check({pfx, "_seq_pc"}, instr_pc, 32'(4 * i));
            check({pfx, "_seq_instr"}, instr, 32'hA000_0000 | 32'(4 * i));
        end
    endtask

    initial begin
        reset        = 1'b1;
        instr_ready  = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        reset2       = 1'b1;
        instr_ready2 = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_rd_en", 32'(imem_rd_en), 32'h0);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_mis", 32'(misaligned), 32'h0);
        check("rst2_addr", 32'(imem_addr2), 32'h3FE);

        // 1: boot and steady stream
        release_and_check_boot("t1");

        // 2: decode stalled, FIFO fills to depth then drains without gaps
        reset = 1'b1;
        instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_rd_en) reads++;
            tick();
        end
        check("t2_reads", 32'(reads), 32'd4);
        check("t2_rd_en_full", 32'(imem_rd_en), 32'h0);
        check("t2_held_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t2_drain_valid", 32'(instr_valid), 32'h1);
            check("t2_drain_pc", instr_pc, 32'(4 * i));
            tick();
        end

        // 3: redirect with 3 queued and 1 in flight
        reset = 1'b1;
        instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t3_pre_valid", 32'(instr_valid), 32'h1);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("t3_redir_rd_en", 32'(imem_rd_en), 32'h0);
        tick();
        redirect = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("t3_flush_valid", 32'(instr_valid), 32'h0);
        check("t3_flush_addr", 32'(imem_addr), 32'h040);
        check("t3_flush_rd_en", 32'(imem_rd_en), 32'h1);
        check("t3_flush_mis", 32'(misaligned), 32'h0);
        tick();
        check("t3_issue_valid", 32'(instr_valid), 32'h0);
        tick();
        check("t3_ret_valid", 32'(instr_valid), 32'h1);
        check("t3_ret_pc", instr_pc, 32'h100);
        check("t3_ret_instr", instr, 32'hA000_0100);
        tick();
        check("t3_next_pc", instr_pc, 32'h104);

        // 4: misaligned redirect
        redirect = 1'b1;
        redirect_pc = 32'h102;
        #1;
        check("t4_redir_rd_en", 32'(imem_rd_en), 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        check("t4_mis_pulse", 32'(misaligned), 32'h1);
        check("t4_addr", 32'(imem_addr), 32'h040);
        check("t4_flush_valid", 32'(instr_valid), 32'h0);
        tick();
        check("t4_mis_clear", 32'(misaligned), 32'h0);
        check("t4_issue_valid", 32'(instr_valid), 32'h0);
        tick();
        check("t4_ret_valid", 32'(instr_valid), 32'h1);
        check("t4_ret_pc", instr_pc, 32'h100);

        // 5: PC wrap from RESET_PC = 0xFFFF_FFF8
        reset2 = 1'b0;
        #1;
        tick();
        check("t5_c1_addr", 32'(imem_addr2), 32'h3FE);
        check("t5_c1_rd_en", 32'(imem_rd_en2), 32'h1);
        tick();
        check("t5_c2_addr", 32'(imem_addr2), 32'h3FF);
        tick();
        check("t5_c3_addr", 32'(imem_addr2), 32'h000);
        check("t5_pc0", instr_pc2, 32'hFFFF_FFF8);
        check("t5_instr0", instr2, 32'hA000_0FF8);
        tick();
        check("t5_pc1", instr_pc2, 32'hFFFF_FFFC);
        tick();
        check("t5_pc2", instr_pc2, 32'h0);
        check("t5_instr2", instr2, 32'hA000_0000);

        // 6: async reset mid-cycle with FIFO full
        reset = 1'b1;
        instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t6_full_valid", 32'(instr_valid), 32'h1);
        check("t6_full_rd_en", 32'(imem_rd_en), 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(instr_valid), 32'h0);
        check("t6_async_instr", instr, 32'h0);
        check("t6_async_pc", instr_pc, 32'h0);
        check("t6_async_addr", 32'(imem_addr), 32'h0);
        instr_ready = 1'b1;
        release_and_check_boot("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
